// File: rtl/regs_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package regs_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 2;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam word_t     ZERO_WORD = 32'h0;
    localparam reg_addr_t ZERO_REG  = 5'h0;
    localparam cnt_t      CNT_MAX   = '1;
    localparam cnt_t      CNT_ONE   = cnt_t'(1);

endpackage

// File: rtl/regs_if.sv
// Decode read, issue and writeback signals between the pipeline and the register file.
interface regs_if;
    import regs_pkg::*;

    reg_addr_t rs1_addr_i;
    reg_addr_t rs2_addr_i;
    word_t     rs1_data_o;
    word_t     rs2_data_o;
    reg_addr_t rd_addr_i;
    word_t     rd_data_i;
    logic      reg_wen_i;
    logic      iss_valid_i;
    reg_addr_t iss_rd_i;
    logic      iss_wen_i;
    logic      stall_o;
    logic      ovf_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, reg_wen_i,
               iss_valid_i, iss_rd_i, iss_wen_i,
        input  rs1_data_o, rs2_data_o, stall_o, ovf_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, rd_addr_i, rd_data_i, reg_wen_i,
               iss_valid_i, iss_rd_i, iss_wen_i,
        output rs1_data_o, rs2_data_o, stall_o, ovf_o
    );

endinterface

// File: rtl/regs_sb.sv
// Pending-write scoreboard: one saturating counter per register plus RAW hazard detect.
module regs_sb
    import regs_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  reg_addr_t rd_addr,
    input  logic      reg_wen,
    input  logic      iss_valid,
    input  reg_addr_t iss_rd,
    input  logic      iss_wen,
    output logic      stall,
    output logic      ovf
);

    cnt_t cnt_q [NREG];
    cnt_t cnt_d [NREG];
    logic ovf_q;
    logic ovf_set;
    logic busy1;
    logic busy2;
    logic inc;
    logic dec;

    // A source is busy while writers are pending, unless the last one retires now (its data is bypassed).
    always_comb begin
        busy1 = (rs1_addr != ZERO_REG) && (cnt_q[rs1_addr] != '0) &&
                !(reg_wen && (rd_addr == rs1_addr) && (cnt_q[rs1_addr] == CNT_ONE));
        busy2 = (rs2_addr != ZERO_REG) && (cnt_q[rs2_addr] != '0) &&
                !(reg_wen && (rd_addr == rs2_addr) && (cnt_q[rs2_addr] == CNT_ONE));
        stall = busy1 | busy2;
    end

    // Next counter values; saturating at both ends and flagging the event. x0 never tracks writers.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = iss_valid && iss_wen && (iss_rd == reg_addr_t'(r)) && !stall;
            dec = reg_wen && (rd_addr == reg_addr_t'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CNT_MAX) ovf_set = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) ovf_set = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // Counter array and sticky overflow flag; reset drops all pending state at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_q | ovf_set;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: rtl/regs.sv
// Integer register file: two combinational read ports with write-through bypass, one write port.
module regs
    import regs_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    regs_if.slave bus
);

    word_t mem [NREG];
    word_t rs1_data;
    word_t rs2_data;

    // Storage; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= ZERO_WORD;
        end else if (bus.reg_wen_i && (bus.rd_addr_i != ZERO_REG)) begin
            mem[bus.rd_addr_i] <= bus.rd_data_i;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write to the address is forwarded, else the stored value.
    always_comb begin
        rs1_data = mem[bus.rs1_addr_i];
        rs2_data = mem[bus.rs2_addr_i];
        if (bus.rs1_addr_i == ZERO_REG)
            rs1_data = ZERO_WORD;
        else if (bus.reg_wen_i && (bus.rd_addr_i == bus.rs1_addr_i))
            rs1_data = bus.rd_data_i;
        if (bus.rs2_addr_i == ZERO_REG)
            rs2_data = ZERO_WORD;
        else if (bus.reg_wen_i && (bus.rd_addr_i == bus.rs2_addr_i))
            rs2_data = bus.rd_data_i;
    end

    assign bus.rs1_data_o = rs1_data;
    assign bus.rs2_data_o = rs2_data;

    regs_sb u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_addr  (bus.rs1_addr_i),
        .rs2_addr  (bus.rs2_addr_i),
        .rd_addr   (bus.rd_addr_i),
        .reg_wen   (bus.reg_wen_i),
        .iss_valid (bus.iss_valid_i),
        .iss_rd    (bus.iss_rd_i),
        .iss_wen   (bus.iss_wen_i),
        .stall     (bus.stall_o),
        .ovf       (bus.ovf_o)
    );

endmodule

// File: tb/tb_regs.sv
// Testbench for regs: directed steps followed by random traffic, checked against a behavioural model.
module tb_regs;

    logic clk;
    logic rst_n;
    regs_if bus ();

    regs u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [32];
    int          m_cnt [32];
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
    endtask

    function automatic bit m_busy(int a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (bus.reg_wen_i && int'(bus.rd_addr_i) == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return m_busy(int'(bus.rs1_addr_i)) || m_busy(int'(bus.rs2_addr_i));
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'h0;
        if (bus.reg_wen_i && int'(bus.rd_addr_i) == a) return bus.rd_data_i;
        return m_mem[a];
    endfunction

    task automatic idle();
        bus.rs1_addr_i  = '0;
        bus.rs2_addr_i  = '0;
        bus.rd_addr_i   = '0;
        bus.rd_data_i   = '0;
        bus.reg_wen_i   = 1'b0;
        bus.iss_valid_i = 1'b0;
        bus.iss_rd_i    = '0;
        bus.iss_wen_i   = 1'b0;
    endtask

    // Let combinational outputs settle and compare them with the model.
    task automatic settle();
        #1;
        chk("rs1_data", bus.rs1_data_o, m_read(int'(bus.rs1_addr_i)));
        chk("rs2_data", bus.rs2_data_o, m_read(int'(bus.rs2_addr_i)));
        chk("stall", {31'b0, bus.stall_o}, {31'b0, m_stall()});
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic clk_step();
        logic [31:0] n_mem [32];
        int          n_cnt [32];
        bit          n_ovf;
        bit          s;
        bit          inc, dec;
        s = m_stall();
        n_mem = m_mem;
        n_cnt = m_cnt;
        n_ovf = m_ovf;
        for (int r = 1; r < 32; r++) begin
            inc = bus.iss_valid_i && bus.iss_wen_i && int'(bus.iss_rd_i) == r && !s;
            dec = bus.reg_wen_i && int'(bus.rd_addr_i) == r;
            if (inc && !dec) begin
                if (m_cnt[r] == 3) n_ovf = 1'b1;
                else               n_cnt[r] = m_cnt[r] + 1;
            end else if (dec && !inc) begin
                if (m_cnt[r] == 0) n_ovf = 1'b1;
                else               n_cnt[r] = m_cnt[r] - 1;
            end
        end
        if (bus.reg_wen_i && bus.rd_addr_i != 0) n_mem[bus.rd_addr_i] = bus.rd_data_i;
        @(posedge clk);
        m_mem = n_mem;
        m_cnt = n_cnt;
        m_ovf = n_ovf;
        #1;
        chk("ovf", {31'b0, bus.ovf_o}, {31'b0, m_ovf});
        @(negedge clk);
    endtask

    task automatic issue(input int r);
        idle();
        bus.iss_valid_i = 1'b1;
        bus.iss_wen_i   = 1'b1;
        bus.iss_rd_i    = 5'(r);
        settle();
        clk_step();
    endtask

    task automatic retire(input int r, input logic [31:0] d);
        idle();
        bus.reg_wen_i = 1'b1;
        bus.rd_addr_i = 5'(r);
        bus.rd_data_i = d;
        settle();
        clk_step();
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state: every register reads zero, no stall, no overflow.
        for (int a = 1; a < 32; a++) begin
            idle();
            bus.rs1_addr_i = 5'(a);
            bus.rs2_addr_i = 5'(32 - a);
            settle();
            chk("reset_rs1", bus.rs1_data_o, 32'h0);
            chk("reset_stall", {31'b0, bus.stall_o}, 32'h0);
            chk("reset_ovf", {31'b0, bus.ovf_o}, 32'h0);
            clk_step();
        end

        // Write then read back; write to x0 is ignored.
        retire(5, 32'hDEADBEEF);
        idle();
        bus.rs1_addr_i = 5'd5;
        settle();
        chk("wr_x5", bus.rs1_data_o, 32'hDEADBEEF);
        clk_step();
        retire(0, 32'h1234);
        idle();
        bus.rs2_addr_i = 5'd0;
        settle();
        chk("wr_x0", bus.rs2_data_o, 32'h0);
        clk_step();

        // Write-through bypass on both ports.
        idle();
        bus.reg_wen_i  = 1'b1;
        bus.rd_addr_i  = 5'd7;
        bus.rd_data_i  = 32'hA5A5A5A5;
        bus.rs1_addr_i = 5'd7;
        bus.rs2_addr_i = 5'd7;
        settle();
        chk("byp_rs1", bus.rs1_data_o, 32'hA5A5A5A5);
        chk("byp_rs2", bus.rs2_data_o, 32'hA5A5A5A5);
        clk_step();

        // Hazard on a single pending writer, released by its own writeback.
        sync_reset();
        issue(3);
        idle();
        bus.rs2_addr_i = 5'd3;
        settle();
        chk("haz_stall", {31'b0, bus.stall_o}, 32'h1);
        clk_step();
        idle();
        bus.rs2_addr_i = 5'd3;
        bus.reg_wen_i  = 1'b1;
        bus.rd_addr_i  = 5'd3;
        bus.rd_data_i  = 32'h42;
        settle();
        chk("haz_release", {31'b0, bus.stall_o}, 32'h0);
        chk("haz_data", bus.rs2_data_o, 32'h42);
        clk_step();
        idle();
        bus.rs2_addr_i = 5'd3;
        settle();
        chk("haz_cleared", {31'b0, bus.stall_o}, 32'h0);
        chk("haz_no_ovf", {31'b0, bus.ovf_o}, 32'h0);
        clk_step();

        // Multiple writers to x9: three issues, one retire -> 2 pending.
        issue(9);
        issue(9);
        issue(9);
        retire(9, 32'h11);
        idle();
        bus.rs1_addr_i = 5'd9;
        settle();
        chk("multi_stall", {31'b0, bus.stall_o}, 32'h1);
        clk_step();
        idle();
        bus.iss_valid_i = 1'b1;
        bus.iss_wen_i   = 1'b1;
        bus.iss_rd_i    = 5'd9;
        bus.reg_wen_i   = 1'b1;
        bus.rd_addr_i   = 5'd9;
        bus.rd_data_i   = 32'h22;
        settle();
        clk_step();
        issue(9);
        chk("sat_no_ovf_yet", {31'b0, bus.ovf_o}, 32'h0);
        issue(9);
        chk("sat_ovf", {31'b0, bus.ovf_o}, 32'h1);

        // Asynchronous reset in the middle of a cycle clears pending state immediately.
        idle();
        bus.rs1_addr_i = 5'd9;
        settle();
        chk("pre_rst_stall", {31'b0, bus.stall_o}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_ovf", {31'b0, bus.ovf_o}, 32'h0);
        chk("async_stall", {31'b0, bus.stall_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Underflow on x10: flag sets and the write still lands.
        retire(10, 32'h77);
        chk("udf_ovf", {31'b0, bus.ovf_o}, 32'h1);
        idle();
        bus.rs1_addr_i = 5'd10;
        settle();
        chk("udf_write", bus.rs1_data_o, 32'h77);
        clk_step();

        // Random traffic over a small address window for frequent collisions.
        sync_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) sync_reset();
            bus.rs1_addr_i  = 5'($urandom_range(0, 7));
            bus.rs2_addr_i  = 5'($urandom_range(0, 7));
            bus.rd_addr_i   = 5'($urandom_range(0, 7));
            bus.rd_data_i   = $urandom;
            bus.reg_wen_i   = ($urandom_range(0, 2) == 0);
            bus.iss_valid_i = ($urandom_range(0, 1) == 1);
            bus.iss_wen_i   = ($urandom_range(0, 3) != 0);
            bus.iss_rd_i    = 5'($urandom_range(0, 7));
            settle();
            clk_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
